// File: rtl/reward_pkg.sv
// Shared types and constants for the reward effect controller and its per-effect timers.
package reward_pkg;

    localparam int unsigned CNT_W    = 6;

    localparam int unsigned EFF_INV  = 0;
    localparam int unsigned EFF_FAST = 1;
    localparam int unsigned EFF_FRZ  = 2;
    localparam int unsigned EFF_LSR  = 3;
    localparam int unsigned EFF_N    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        WARN   = 2'd2
    } eff_state_t;

    function automatic logic [CNT_W-1:0] cnt_max(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reward_effect_timer.sv
// One timed effect: synchronises its reward level, detects rises and runs
// the IDLE/ACTIVE/WARN countdown driven by the shared 4 Hz tick.
module reward_effect_timer
    import reward_pkg::*;
#(
    parameter int unsigned DURATION_TICKS = 30,
    parameter int unsigned WARN_TICKS     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic             i_tick,
    input  logic             i_reward,
    output logic             o_effect,
    output logic             o_warn,
    output logic [CNT_W-1:0] o_count
);

    logic [1:0]       r_sync;
    logic             r_prev;
    logic [1:0]       r_fill;
    logic             r_armed;
    eff_state_t       r_state;
    logic [CNT_W-1:0] r_count;

    logic             w_rise;
    logic [CNT_W-1:0] w_dec;

    // A rise only counts once the synchronised level has been seen low after
    // reset, so a level already high at reset release is ignored.
    assign w_rise = r_sync[1] & ~r_prev & r_armed;
    assign w_dec  = r_count - CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_prev  <= 1'b0;
            r_fill  <= '0;
            r_armed <= 1'b0;
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_sync  <= {r_sync[0], i_reward};
            r_prev  <= r_sync[1];
            r_fill  <= {r_fill[0], 1'b1};
            r_armed <= r_armed | (r_fill[1] & ~r_sync[1]);

            if (!i_enable) begin
                r_state <= IDLE;
                r_count <= '0;
            end else if (w_rise) begin
                r_state <= ACTIVE;
                r_count <= CNT_W'(DURATION_TICKS);
            end else if (i_tick) begin
                case (r_state)
                    ACTIVE, WARN: begin
                        if (r_count == '0) begin
                            r_state <= IDLE;
                        end else begin
                            r_count <= w_dec;
                            if (w_dec == '0)
                                r_state <= IDLE;
                            else if (w_dec <= CNT_W'(WARN_TICKS))
                                r_state <= WARN;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_effect = (r_state != IDLE);
    assign o_warn   = (r_state == WARN);
    assign o_count  = r_count;

endmodule

// File: rtl/reward_effect_ctrl.sv
// Reward effect controller: four timed effects, tank move divider, add-time
// strobe, expiry blink and remaining-time maximum.
module reward_effect_ctrl
    import reward_pkg::*;
#(
    parameter int unsigned DURATION_TICKS = 30,
    parameter int unsigned WARN_TICKS     = 8,
    parameter int unsigned NORMAL_DIV     = 2500000,
    parameter int unsigned FAST_DIV       = 1250000,
    parameter int unsigned ADDTIME_SEC    = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_4Hz,
    input  logic       enable_reward,
    input  logic       reward_invincible,
    input  logic       reward_addtime,
    input  logic       reward_faster,
    input  logic       reward_frozen,
    input  logic       reward_laser,
    output logic       effect_invincible,
    output logic       effect_frozen,
    output logic       effect_laser,
    output logic       effect_faster,
    output logic       tank_move_tick,
    output logic       addtime_pulse,
    output logic [5:0] addtime_value,
    output logic       effect_blink,
    output logic [5:0] remain_max
);

    localparam int unsigned DIV_MAX = (NORMAL_DIV > FAST_DIV) ? NORMAL_DIV : FAST_DIV;
    localparam int unsigned DIV_W   = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;

    logic [1:0]       r_tk_sync;
    logic             r_tk_prev;
    logic             w_tick;

    logic [1:0]       r_at_sync;
    logic             r_at_prev;
    logic [1:0]       r_at_fill;
    logic             r_at_armed;
    logic             w_at_rise;
    logic             r_at_pulse;
    logic [5:0]       r_at_value;

    logic [EFF_N-1:0] w_reward;
    logic [EFF_N-1:0] w_effect;
    logic [EFF_N-1:0] w_warn;
    logic [CNT_W-1:0] w_count [EFF_N];
    logic [CNT_W-1:0] w_max;
    logic [CNT_W-1:0] r_remain_max;

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_period_m1;
    logic             r_fast_q;
    logic             r_move_tick;
    logic             r_blink;

    assign w_tick = r_tk_sync[1] & ~r_tk_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tk_sync <= '0;
            r_tk_prev <= 1'b0;
        end else begin
            r_tk_sync <= {r_tk_sync[0], clk_4Hz};
            r_tk_prev <= r_tk_sync[1];
        end
    end

    assign w_reward[EFF_INV]  = reward_invincible;
    assign w_reward[EFF_FAST] = reward_faster;
    assign w_reward[EFF_FRZ]  = reward_frozen;
    assign w_reward[EFF_LSR]  = reward_laser;

    for (genvar g = 0; g < EFF_N; g++) begin : g_timer
        reward_effect_timer #(
            .DURATION_TICKS (DURATION_TICKS),
            .WARN_TICKS     (WARN_TICKS)
        ) u_timer (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_enable (enable_reward),
            .i_tick   (w_tick),
            .i_reward (w_reward[g]),
            .o_effect (w_effect[g]),
            .o_warn   (w_warn[g]),
            .o_count  (w_count[g])
        );
    end

    assign effect_invincible = w_effect[EFF_INV];
    assign effect_faster     = w_effect[EFF_FAST];
    assign effect_frozen     = w_effect[EFF_FRZ];
    assign effect_laser      = w_effect[EFF_LSR];

    // Same armed edge detector as the timers so a held level never re-pulses.
    assign w_at_rise = r_at_sync[1] & ~r_at_prev & r_at_armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_at_sync  <= '0;
            r_at_prev  <= 1'b0;
            r_at_fill  <= '0;
            r_at_armed <= 1'b0;
            r_at_pulse <= 1'b0;
            r_at_value <= '0;
        end else begin
            r_at_sync  <= {r_at_sync[0], reward_addtime};
            r_at_prev  <= r_at_sync[1];
            r_at_fill  <= {r_at_fill[0], 1'b1};
            r_at_armed <= r_at_armed | (r_at_fill[1] & ~r_at_sync[1]);
            if (w_at_rise && enable_reward) begin
                r_at_pulse <= 1'b1;
                r_at_value <= 6'(ADDTIME_SEC);
            end else begin
                r_at_pulse <= 1'b0;
                r_at_value <= '0;
            end
        end
    end

    assign addtime_pulse = r_at_pulse;
    assign addtime_value = r_at_value;

    assign w_period_m1 = effect_faster ? DIV_W'(FAST_DIV - 1) : DIV_W'(NORMAL_DIV - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div       <= '0;
            r_fast_q    <= 1'b0;
            r_move_tick <= 1'b0;
        end else begin
            r_fast_q <= effect_faster;
            if (effect_faster != r_fast_q) begin
                r_div       <= '0;
                r_move_tick <= 1'b0;
            end else if (r_div >= w_period_m1) begin
                r_div       <= '0;
                r_move_tick <= 1'b1;
            end else begin
                r_div       <= r_div + DIV_W'(1);
                r_move_tick <= 1'b0;
            end
        end
    end

    assign tank_move_tick = r_move_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_blink <= 1'b0;
        else if (!enable_reward || !(|w_warn))
            r_blink <= 1'b0;
        else if (w_tick)
            r_blink <= ~r_blink;
    end

    assign effect_blink = r_blink;

    always_comb begin
        w_max = '0;
        for (int unsigned i = 0; i < EFF_N; i++)
            w_max = cnt_max(w_max, w_count[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_remain_max <= '0;
        else
            r_remain_max <= w_max;
    end

    assign remain_max = r_remain_max;

endmodule

// File: tb/tb_reward_effect_ctrl.sv
// Self-checking bench for reward_effect_ctrl with short divider periods.
module tb_reward_effect_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_4Hz;
    logic       enable_reward;
    logic       reward_invincible;
    logic       reward_addtime;
    logic       reward_faster;
    logic       reward_frozen;
    logic       reward_laser;
    logic       effect_invincible;
    logic       effect_frozen;
    logic       effect_laser;
    logic       effect_faster;
    logic       tank_move_tick;
    logic       addtime_pulse;
    logic [5:0] addtime_value;
    logic       effect_blink;
    logic [5:0] remain_max;

    int checks = 0;
    int errors = 0;
    int n_at   = 0;
    int exp_q[$];

    reward_effect_ctrl #(
        .DURATION_TICKS (30),
        .WARN_TICKS     (8),
        .NORMAL_DIV     (10),
        .FAST_DIV       (4),
        .ADDTIME_SEC    (10)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .clk_4Hz           (clk_4Hz),
        .enable_reward     (enable_reward),
        .reward_invincible (reward_invincible),
        .reward_addtime    (reward_addtime),
        .reward_faster     (reward_faster),
        .reward_frozen     (reward_frozen),
        .reward_laser      (reward_laser),
        .effect_invincible (effect_invincible),
        .effect_frozen     (effect_frozen),
        .effect_laser      (effect_laser),
        .effect_faster     (effect_faster),
        .tank_move_tick    (tank_move_tick),
        .addtime_pulse     (addtime_pulse),
        .addtime_value     (addtime_value),
        .effect_blink      (effect_blink),
        .remain_max        (remain_max)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick4();
        clk_4Hz = 1'b1;
        cyc(4);
        clk_4Hz = 1'b0;
        cyc(4);
    endtask

    task automatic meas_period(input string tag, input int exp);
        int c;
        c = 0;
        while (!tank_move_tick && c < 100) begin
            @(negedge clk);
            c++;
        end
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!tank_move_tick && c < 100);
        check(tag, c, exp);
    endtask

    // Scoreboard: every add-time rise driven while enabled pushes its expected value.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (addtime_pulse === 1'b1) begin
                n_at++;
                if (exp_q.size() == 0)
                    check("at_extra_pulse", 1, 0);
                else
                    check("at_value", addtime_value, exp_q.pop_front());
            end else begin
                check("at_idle_value", addtime_value, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        clk_4Hz = 1'b0;
        enable_reward = 1'b1;
        reward_invincible = 1'b0;
        reward_addtime = 1'b0;
        reward_faster = 1'b0;
        reward_frozen = 1'b1;
        reward_laser = 1'b0;
        cyc(3);

        check("rst_inv", effect_invincible, 0);
        check("rst_frz", effect_frozen, 0);
        check("rst_lsr", effect_laser, 0);
        check("rst_fast", effect_faster, 0);
        check("rst_move", tank_move_tick, 0);
        check("rst_at", addtime_pulse, 0);
        check("rst_blink", effect_blink, 0);
        check("rst_remain", remain_max, 0);

        // Held level across reset release must not start an effect.
        rst_n = 1'b1;
        cyc(10);
        check("frz_held_after_rst", effect_frozen, 0);
        check("remain_held_after_rst", remain_max, 0);
        reward_frozen = 1'b0;
        cyc(5);
        reward_frozen = 1'b1;
        cyc(2);
        check("frz_lat2", effect_frozen, 0);
        cyc(1);
        check("frz_lat3", effect_frozen, 1);
        cyc(1);
        check("frz_remain", remain_max, 30);
        reward_frozen = 1'b0;

        // Enable drop clears active effects.
        reward_invincible = 1'b1;
        cyc(4);
        reward_invincible = 1'b0;
        check("inv_on", effect_invincible, 1);
        enable_reward = 1'b0;
        cyc(1);
        check("dis_inv", effect_invincible, 0);
        check("dis_frz", effect_frozen, 0);
        cyc(1);
        check("dis_remain", remain_max, 0);
        enable_reward = 1'b1;
        cyc(10);
        check("reen_inv", effect_invincible, 0);
        check("reen_frz", effect_frozen, 0);
        check("reen_remain", remain_max, 0);

        // Laser full lifetime with WARN blink.
        reward_laser = 1'b1;
        cyc(4);
        reward_laser = 1'b0;
        check("lsr_on", effect_laser, 1);
        check("lsr_remain0", remain_max, 30);
        for (int k = 1; k <= 30; k++) begin
            tick4();
            check($sformatf("lsr_remain_%0d", k), remain_max, 30 - k);
            if (k >= 22 && k <= 29)
                check($sformatf("lsr_blink_%0d", k), effect_blink, (k - 22) & 1);
            if (k == 29)
                check("lsr_still_on", effect_laser, 1);
        end
        check("lsr_off", effect_laser, 0);
        check("lsr_blink_off", effect_blink, 0);

        // Reload in the same cycle as a tick wins over the decrement.
        reward_invincible = 1'b1;
        cyc(4);
        reward_invincible = 1'b0;
        for (int k = 0; k < 25; k++)
            tick4();
        check("inv_remain5", remain_max, 5);
        clk_4Hz = 1'b1;
        reward_invincible = 1'b1;
        cyc(4);
        check("reload_remain", remain_max, 30);
        check("reload_on", effect_invincible, 1);
        clk_4Hz = 1'b0;
        reward_invincible = 1'b0;
        cyc(4);
        check("reload_blink", effect_blink, 0);
        tick4();
        check("reload_dec", remain_max, 29);
        check("reload_blink2", effect_blink, 0);
        enable_reward = 1'b0;
        cyc(2);
        enable_reward = 1'b1;
        cyc(2);

        // Move divider at normal and fast rates.
        meas_period("div_norm", 10);
        reward_faster = 1'b1;
        cyc(4);
        reward_faster = 1'b0;
        check("fast_on", effect_faster, 1);
        meas_period("div_fast", 4);
        meas_period("div_fast2", 4);
        for (int k = 0; k < 30; k++)
            tick4();
        check("fast_off", effect_faster, 0);
        meas_period("div_slow", 10);

        // Add-time: one pulse for a long held level, none while disabled.
        reward_addtime = 1'b1;
        exp_q.push_back(10);
        cyc(100);
        reward_addtime = 1'b0;
        cyc(10);
        enable_reward = 1'b0;
        reward_addtime = 1'b1;
        cyc(10);
        reward_addtime = 1'b0;
        cyc(5);
        enable_reward = 1'b1;
        cyc(5);
        check("at_pending", exp_q.size(), 0);
        check("at_count", n_at, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
